// File: rtl/dmem_pkg.sv
// Shared definitions for the MEM-stage data memory responder: size encodings,
// FSM state type and the byte-lane store/load formatting helpers.
package dmem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2
  } size_e;

  // Reserved encodings 011/110/111 behave as a word access
  function automatic size_e f3_size(input logic [2:0] f3);
    case (f3)
      F3_B, F3_BU: f3_size = SZ_B;
      F3_H, F3_HU: f3_size = SZ_H;
      default:     f3_size = SZ_W;
    endcase
  endfunction

  function automatic logic [3:0] byte_en(input logic [2:0] f3, input logic [1:0] lane);
    case (f3_size(f3))
      SZ_B:    byte_en = 4'b0001 << lane;
      SZ_H:    byte_en = lane[1] ? 4'b1100 : 4'b0011;
      default: byte_en = 4'b1111;
    endcase
  endfunction

  // Right-aligned store data replicated so every candidate lane carries it
  function automatic logic [31:0] store_align(input logic [2:0] f3, input logic [31:0] data);
    case (f3_size(f3))
      SZ_B:    store_align = {4{data[7:0]}};
      SZ_H:    store_align = {2{data[15:0]}};
      default: store_align = data;
    endcase
  endfunction

  function automatic logic [31:0] load_fmt(input logic [2:0] f3, input logic [1:0] lane,
                                           input logic [31:0] word);
    logic [7:0]  b;
    logic [15:0] h;
    b = 8'(word >> {lane, 3'b000});
    h = lane[1] ? word[31:16] : word[15:0];
    case (f3)
      F3_B:    load_fmt = {{24{b[7]}}, b};
      F3_BU:   load_fmt = {24'h000000, b};
      F3_H:    load_fmt = {{16{h[15]}}, h};
      F3_HU:   load_fmt = {16'h0000, h};
      default: load_fmt = word;
    endcase
  endfunction

  function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] lane);
    case (f3_size(f3))
      SZ_H:    is_misaligned = lane[0];
      SZ_W:    is_misaligned = (lane != 2'b00);
      default: is_misaligned = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// MEM-stage request/response bundle between the pipeline (master) and the
// data memory responder (slave).
interface dmem_responder_if;
  logic        MemReadM;
  logic        MemWriteM;
  logic [31:0] ALUResultM;
  logic [31:0] WriteDataM;
  logic [2:0]  Funct3M;
  logic        StallM;
  logic [31:0] ReadDataM;
  logic        ReadValidM;
  logic        MisalignM;

  modport master (
    output MemReadM, MemWriteM, ALUResultM, WriteDataM, Funct3M,
    input  StallM, ReadDataM, ReadValidM, MisalignM
  );

  modport slave (
    input  MemReadM, MemWriteM, ALUResultM, WriteDataM, Funct3M,
    output StallM, ReadDataM, ReadValidM, MisalignM
  );
endinterface

// File: rtl/dmem_array.sv
// Word-organised data storage: synchronous byte-enabled write, combinational
// read at the same word index. Contents are intentionally not reset.
module dmem_array #(
  parameter int DEPTH_WORDS = 1024,
  parameter int ADDR_W      = $clog2(DEPTH_WORDS)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [3:0]        be,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata
);

  logic [31:0] mem_q [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) begin
          mem_q[addr][8*i +: 8] <= wdata[8*i +: 8];
        end
      end
    end
  end

  assign rdata = mem_q[addr];

endmodule

// File: rtl/dmem_responder.sv
// MEM-stage data memory responder: IDLE/BUSY/DONE access FSM with WAIT_STATES
// busy cycles. Optional misalignment trap under DMEM_MISALIGN_TRAP_EN.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_STATES = 2
) (
  input  logic             CLK,
  input  logic             RST,
  dmem_responder_if.slave  bus
);

  localparam int ADDR_W = $clog2(DEPTH_WORDS);

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [ADDR_W+1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [2:0]        f3_q, f3_d;
  logic              is_store_q, is_store_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              rvalid_q, rvalid_d;
  logic              mis_q, mis_d;

  logic              req_s;
  logic              finish_s;
  logic              misalign_s;
  logic              we_s;
  logic [31:0]       arr_rdata_s;
  logic              unused_addr_s;

  assign req_s         = bus.MemReadM | bus.MemWriteM;
  assign finish_s      = (state_q == ST_BUSY) && (cnt_q == 4'd0);
  assign unused_addr_s = ^bus.ALUResultM[31:ADDR_W+2];

`ifdef DMEM_MISALIGN_TRAP_EN
  assign misalign_s = is_misaligned(f3_q, addr_q[1:0]);
`else
  assign misalign_s = 1'b0;
`endif

  // A reset landing on the commit edge must drop the store
  assign we_s = finish_s & is_store_q & ~misalign_s & ~RST;

  dmem_array #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .ADDR_W      (ADDR_W)
  ) u_array (
    .clk   (CLK),
    .we    (we_s),
    .be    (byte_en(f3_q, addr_q[1:0])),
    .addr  (addr_q[ADDR_W+1:2]),
    .wdata (store_align(f3_q, wdata_q)),
    .rdata (arr_rdata_s)
  );

  // Next-state, capture and response computation
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    f3_d       = f3_q;
    is_store_d = is_store_q;
    rdata_d    = rdata_q;
    rvalid_d   = 1'b0;
    mis_d      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req_s) begin
          state_d    = ST_BUSY;
          cnt_d      = 4'(WAIT_STATES);
          addr_d     = bus.ALUResultM[ADDR_W+1:0];
          wdata_d    = bus.WriteDataM;
          f3_d       = bus.Funct3M;
          is_store_d = bus.MemWriteM;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_BUSY: begin
        if (cnt_q == 4'd0) begin
          state_d = ST_DONE;
          if (misalign_s) begin
            mis_d = 1'b1;
          end else if (!is_store_q) begin
            rdata_d  = load_fmt(f3_q, addr_q[1:0], arr_rdata_s);
            rvalid_d = 1'b1;
          end else begin
            rdata_d = rdata_q;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // FSM and response registers
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= ST_IDLE;
      cnt_q      <= 4'd0;
      addr_q     <= '0;
      wdata_q    <= 32'h0000_0000;
      f3_q       <= 3'b000;
      is_store_q <= 1'b0;
      rdata_q    <= 32'h0000_0000;
      rvalid_q   <= 1'b0;
      mis_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      f3_q       <= f3_d;
      is_store_q <= is_store_d;
      rdata_q    <= rdata_d;
      rvalid_q   <= rvalid_d;
      mis_q      <= mis_d;
    end
  end

  // Stall is combinational in IDLE so the pipeline freezes on the request cycle
  assign bus.StallM     = ((state_q == ST_IDLE) && req_s) || (state_q == ST_BUSY);
  assign bus.ReadDataM  = rdata_q;
  assign bus.ReadValidM = rvalid_q;
  assign bus.MisalignM  = mis_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: two instances (WAIT_STATES 2 and 0) checked against
// a byte-addressed memory model. Follows DMEM_MISALIGN_TRAP_EN like the RTL.
`timescale 1ns/1ps
module tb_dmem_responder;

  localparam int WS_A = 2;
  localparam int WS_B = 0;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dmem_responder_if bus_a ();
  dmem_responder_if bus_b ();

  dmem_responder #(.DEPTH_WORDS(1024), .WAIT_STATES(WS_A)) dut_a (
    .CLK (clk), .RST (rst), .bus (bus_a)
  );
  dmem_responder #(.DEPTH_WORDS(1024), .WAIT_STATES(WS_B)) dut_b (
    .CLK (clk), .RST (rst), .bus (bus_b)
  );

  int          n_assert = 0;
  int          n_fail   = 0;
  logic [7:0]  model_mem [2][4096];
  logic [31:0] model_rd  [2];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int u, input logic rd, input logic wr, input logic [31:0] addr,
                       input logic [31:0] data, input logic [2:0] f3);
    if (u == 0) begin
      bus_a.MemReadM = rd; bus_a.MemWriteM = wr; bus_a.ALUResultM = addr;
      bus_a.WriteDataM = data; bus_a.Funct3M = f3;
    end else begin
      bus_b.MemReadM = rd; bus_b.MemWriteM = wr; bus_b.ALUResultM = addr;
      bus_b.WriteDataM = data; bus_b.Funct3M = f3;
    end
  endtask

  task automatic sample(input int u, output logic st, output logic rv, output logic ms,
                        output logic [31:0] rd);
    if (u == 0) begin
      st = bus_a.StallM; rv = bus_a.ReadValidM; ms = bus_a.MisalignM; rd = bus_a.ReadDataM;
    end else begin
      st = bus_b.StallM; rv = bus_b.ReadValidM; ms = bus_b.MisalignM; rd = bus_b.ReadDataM;
    end
  endtask

  function automatic int size_of(input logic [2:0] f3);
    if (f3 == 3'b000 || f3 == 3'b100) return 1;
    if (f3 == 3'b001 || f3 == 3'b101) return 2;
    return 4;
  endfunction

  // One complete access: request cycle, busy cycles, then DONE-cycle response
  task automatic access(input int u, input logic rd, input logic wr, input logic [31:0] addr,
                        input logic [31:0] data, input logic [2:0] f3, input string tag);
    int          ws, sz, base;
    bit          mis;
    logic        st, rv, ms;
    logic [31:0] rdv, v;
    ws   = (u == 0) ? WS_A : WS_B;
    sz   = size_of(f3);
    mis  = 1'b0;
`ifdef DMEM_MISALIGN_TRAP_EN
    mis  = (addr % sz) != 0;
`endif
    base = int'(addr & 32'h0000_0FFF) & ~(sz - 1);
    @(posedge clk); #1;
    drive(1 - u, 1'b0, 1'b0, 32'h0, 32'h0, 3'b010);
    drive(u, rd, wr, addr, data, f3);
    for (int c = 0; c <= ws + 1; c++) begin
      if (c > 0) @(posedge clk);
      @(negedge clk);
      sample(u, st, rv, ms, rdv);
      check({tag, "/stall_busy"}, 32'(st), 32'd1);
      check({tag, "/rvalid_busy"}, 32'(rv), 32'd0);
    end
    if (!mis && wr) begin
      for (int i = 0; i < sz; i++) model_mem[u][base + i] = data[8*i +: 8];
    end else if (!mis) begin
      v = 32'h0;
      for (int i = 0; i < sz; i++) v = v | (32'(model_mem[u][base + i]) << (8 * i));
      if (sz < 4 && (f3 == 3'b000 || f3 == 3'b001) && v[8*sz-1])
        v = v | ~((32'd1 << (8 * sz)) - 32'd1);
      model_rd[u] = v;
    end
    @(posedge clk);
    @(negedge clk);
    sample(u, st, rv, ms, rdv);
    check({tag, "/stall_done"}, 32'(st), 32'd0);
    check({tag, "/rvalid_done"}, 32'(rv), 32'(!wr && !mis));
    check({tag, "/misalign"}, 32'(ms), 32'(mis));
    check({tag, "/rdata"}, rdv, model_rd[u]);
  endtask

  task automatic check_rd(input int u, input string tag, input logic [31:0] exp);
    logic st, rv, ms;
    logic [31:0] rdv;
    sample(u, st, rv, ms, rdv);
    check(tag, rdv, exp);
  endtask

  task automatic go_idle();
    @(posedge clk); #1;
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0, 3'b010);
    drive(1, 1'b0, 1'b0, 32'h0, 32'h0, 3'b010);
  endtask

  initial begin
    logic        st, rv, ms;
    logic [31:0] rdv;
    int          op;
    for (int u = 0; u < 2; u++) begin
      for (int i = 0; i < 4096; i++) model_mem[u][i] = 8'h00;
      model_rd[u] = 32'h0;
    end
    rst = 1'b1;
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0, 3'b010);
    drive(1, 1'b0, 1'b0, 32'h0, 32'h0, 3'b010);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    for (int u = 0; u < 2; u++) begin
      sample(u, st, rv, ms, rdv);
      check("reset/stall", 32'(st), 32'd0);
      check("reset/rvalid", 32'(rv), 32'd0);
      check("reset/misalign", 32'(ms), 32'd0);
      check("reset/rdata", rdv, 32'h0);
    end

    // Directed sequence on the two-wait-state instance
    access(0, 1'b0, 1'b1, 32'h100, 32'hDEADBEEF, 3'b010, "sw_100");
    access(0, 1'b1, 1'b0, 32'h100, 32'h0, 3'b010, "lw_100");
    check_rd(0, "lw_100_const", 32'hDEADBEEF);
    access(0, 1'b1, 1'b0, 32'h103, 32'h0, 3'b000, "lb_103");
    check_rd(0, "lb_103_const", 32'hFFFFFFDE);
    access(0, 1'b1, 1'b0, 32'h103, 32'h0, 3'b100, "lbu_103");
    check_rd(0, "lbu_103_const", 32'h000000DE);
    access(0, 1'b1, 1'b0, 32'h100, 32'h0, 3'b001, "lh_100");
    check_rd(0, "lh_100_const", 32'hFFFFBEEF);
    access(0, 1'b1, 1'b0, 32'h102, 32'h0, 3'b101, "lhu_102");
    check_rd(0, "lhu_102_const", 32'h0000DEAD);
    access(0, 1'b0, 1'b1, 32'h101, 32'h00000055, 3'b000, "sb_101");
    access(0, 1'b1, 1'b0, 32'h100, 32'h0, 3'b010, "lw_100_after_sb");
    check_rd(0, "sb_merge_const", 32'hDEAD55EF);
    access(0, 1'b1, 1'b0, 32'h102, 32'h0, 3'b010, "lw_102_misalign");
    check_rd(0, "lw_102_const", 32'hDEAD55EF);

    // Zero-wait-state instance; both requests high acts as a store
    access(1, 1'b1, 1'b1, 32'h040, 32'hCAFEF00D, 3'b010, "rw_both_ws0");
    access(1, 1'b1, 1'b0, 32'h040, 32'h0, 3'b010, "lw_040_ws0");
    check_rd(1, "lw_040_ws0_const", 32'hCAFEF00D);

    // Reset in the last busy cycle of a store drops it
    access(0, 1'b0, 1'b1, 32'h200, 32'h0, 3'b010, "sw_200_zero");
    @(posedge clk); #1;
    drive(0, 1'b0, 1'b1, 32'h200, 32'h12345678, 3'b010);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0, 3'b010);
    @(negedge clk);
    sample(0, st, rv, ms, rdv);
    check("rst_mid/stall_busy", 32'(st), 32'd1);
    @(posedge clk); #1;
    rst = 1'b0;
    model_rd[0] = 32'h0;
    model_rd[1] = 32'h0;
    @(negedge clk);
    sample(0, st, rv, ms, rdv);
    check("rst_mid/stall_idle", 32'(st), 32'd0);
    check("rst_mid/rdata", rdv, 32'h0);
    access(0, 1'b1, 1'b0, 32'h200, 32'h0, 3'b010, "lw_200_after_rst");
    check_rd(0, "lw_200_const", 32'h0);

    // Randomized traffic over a small, fully initialised region with aliased upper bits
    for (int u = 0; u < 2; u++)
      for (int w = 0; w < 16; w++)
        access(u, 1'b0, 1'b1, 32'(w * 4), 32'h0, 3'b010, "init");
    for (int n = 0; n < 120; n++) begin
      op = int'($urandom_range(0, 2));
      access(n % 2, op != 1, op != 0, $urandom & 32'hFFFF_F03F, $urandom,
             3'($urandom_range(0, 7)), "rand");
    end

    go_idle();
    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
